// File: rtl/baud_ctrl_pkg.sv
// baud_ctrl_pkg: shared types, widths and the measured-count to divisor conversion.
package baud_ctrl_pkg;
   localparam int DVSR_W = 11;
   localparam int CNT_W = 15;
   localparam logic [CNT_W-1:0] CNT_MAX = 15'd32767;
   localparam logic [CNT_W-1:0] CNT_MIN = 15'd16;
   typedef enum logic [1:0] {IDLE, AB_ARM, AB_MEAS, DRAIN} state_t;
   // A start bit lasts 16 oversample ticks, so round count/16 and subtract one for the divider.
   function automatic logic [DVSR_W-1:0] cnt_to_dvsr(input logic [CNT_W-1:0] cnt);
      logic [CNT_W:0] sum;
      logic [CNT_W:0] quo;
      sum = {1'b0, cnt} + 16'd8;
      quo = (sum >> 4) - 16'd1;
      return quo[DVSR_W-1:0];
   endfunction
endpackage

// File: rtl/baud_cfg_ctrl_rx_sync.sv
// rx_sync: two-flop synchronizer for the raw rx line plus a falling-edge strobe.
module rx_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic rx,
   output logic rx_s,
   output logic fall
);
   logic meta_q, sync_q, prev_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rx;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end
   assign rx_s = sync_q;
   assign fall = prev_q & ~sync_q;
endmodule

// File: rtl/baud_cfg_ctrl.sv
// baud_cfg_ctrl: accepts manual or auto-baud divisor requests and commits the
// divisor only while both UART directions are idle.
module baud_cfg_ctrl
   import baud_ctrl_pkg::*;
#(
   parameter logic [10:0] DEFAULT_DVSR = 11'd650
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic        cfg_auto,
   input  logic [10:0] cfg_dvsr,
   input  logic        cfg_abort,
   input  logic        tx_busy,
   input  logic        rx_busy,
   input  logic        rx,
   output logic [10:0] dvsr,
   output logic        cfg_done,
   output logic        cfg_err
);
   state_t state_q, state_d;
   logic [DVSR_W-1:0] dvsr_q, dvsr_d, pend_q, pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic armed_q, armed_d, done_q, done_d, err_q, err_d;
   logic rx_s, fall;

   rx_sync u_sync (.clk(clk), .reset_n(reset_n), .rx(rx), .rx_s(rx_s), .fall(fall));

   always_comb begin
      state_d = state_q;
      dvsr_d  = dvsr_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: if (cfg_valid) begin
            if (cfg_auto) begin
               state_d = AB_ARM;
               armed_d = 1'b0;
            end else begin
               pend_d  = cfg_dvsr;
               state_d = DRAIN;
            end
         end
         AB_ARM: if (cfg_abort) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
         end else begin
            armed_d = armed_q | rx_s;
            if (armed_q && fall) begin
               cnt_d   = CNT_W'(1);
               state_d = AB_MEAS;
            end
         end
         AB_MEAS: if (cfg_abort) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
         end else if (rx_s) begin
            if (cnt_q >= CNT_MIN) begin
               pend_d  = cnt_to_dvsr(cnt_q);
               state_d = DRAIN;
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_MAX) begin
               state_d = IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
         end
         DRAIN: if (!tx_busy && !rx_busy) begin
            dvsr_d  = pend_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         dvsr_q  <= DEFAULT_DVSR;
         pend_q  <= '0;
         cnt_q   <= '0;
         armed_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvsr_q  <= dvsr_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign cfg_ready = (state_q == IDLE);
   assign dvsr      = dvsr_q;
   assign cfg_done  = done_q;
   assign cfg_err   = err_q;
endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// tb_baud_cfg_ctrl: directed requests push expected completions into a queue;
// a negedge monitor pops and checks every cfg_done pulse.
module tb_baud_cfg_ctrl;
   logic clk = 1'b0, reset_n = 1'b0;
   logic cfg_valid = 1'b0, cfg_auto = 1'b0, cfg_abort = 1'b0;
   logic tx_busy = 1'b0, rx_busy = 1'b0, rx = 1'b1;
   logic [10:0] cfg_dvsr = '0;
   logic cfg_ready, cfg_done, cfg_err;
   logic [10:0] dvsr;

   typedef struct {int dv; int err; int cyc;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0, cyc = 0, cur = 650;
   logic [10:0] prev_dvsr = 11'd650;

   baud_cfg_ctrl #(.DEFAULT_DVSR(11'd650)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_auto(cfg_auto), .cfg_dvsr(cfg_dvsr), .cfg_abort(cfg_abort),
      .tx_busy(tx_busy), .rx_busy(rx_busy), .rx(rx),
      .dvsr(dvsr), .cfg_done(cfg_done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (cfg_done) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("done_dvsr", int'(dvsr), e.dv);
               chk("done_err", int'(cfg_err), e.err);
               if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
            end
         end else chk("err_without_done", int'(cfg_err), 0);
         if (!(cfg_done && !cfg_err)) chk("dvsr_hold", int'(dvsr), int'(prev_dvsr));
      end
      prev_dvsr = dvsr;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_q(input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL done_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
      repeat (2) tick();
   endtask

   task automatic manual(input int v);
      chk("ready_idle", int'(cfg_ready), 1);
      cfg_valid = 1'b1;
      cfg_auto  = 1'b0;
      cfg_dvsr  = 11'(v);
      q.push_back('{v, 0, cyc + 2});
      cur = v;
      tick();
      cfg_valid = 1'b0;
      wait_q(20);
   endtask

   task automatic auto_req();
      cfg_valid = 1'b1;
      cfg_auto  = 1'b1;
      cfg_dvsr  = 11'h7ff;
      tick();
      cfg_valid = 1'b0;
      cfg_auto  = 1'b0;
      repeat (3) tick();
   endtask

   task automatic auto_run(input int low, input int err, input int dv);
      q.push_back('{err ? cur : dv, err, -1});
      if (err == 0) cur = dv;
      auto_req();
      rx = 1'b0;
      repeat (low) tick();
      rx = 1'b1;
      wait_q(50);
   endtask

   initial begin
      int n;
      repeat (3) tick();
      chk("reset_dvsr", int'(dvsr), 650);
      chk("reset_done", int'(cfg_done), 0);
      chk("reset_err", int'(cfg_err), 0);
      reset_n = 1'b1;
      tick();
      chk("reset_ready", int'(cfg_ready), 1);

      manual(27);

      // Busy profile: tx high N+1..N+10, rx high N+5..N+12, stray request inside DRAIN.
      cfg_valid = 1'b1;
      cfg_dvsr  = 11'd300;
      n = cyc;
      q.push_back('{300, 0, n + 14});
      tick();
      cfg_valid = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tx_busy = (k <= 10);
         rx_busy = (k >= 5 && k <= 12);
         if (k == 3) begin
            cfg_valid = 1'b1;
            cfg_dvsr  = 11'd77;
         end
         if (k == 4) cfg_valid = 1'b0;
         if (k == 6) chk("ready_drain", int'(cfg_ready), 0);
         if (k == 13) chk("dvsr_before_commit", int'(dvsr), 27);
         tick();
      end
      cur = 300;
      wait_q(20);

      manual(0);
      auto_run(160, 0, 9);
      auto_run(16, 0, 0);
      auto_run(15, 1, 0);
      auto_run(10, 1, 0);
      auto_run(10416, 0, 650);
      manual(5);

      q.push_back('{cur, 1, -1});
      cfg_valid = 1'b1;
      cfg_auto  = 1'b1;
      tick();
      cfg_valid = 1'b0;
      cfg_auto  = 1'b0;
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      wait_q(10);

      auto_req();
      rx = 1'b0;
      repeat (20) tick();
      cfg_abort = 1'b1;
      q.push_back('{cur, 1, cyc + 1});
      tick();
      cfg_abort = 1'b0;
      rx = 1'b1;
      wait_q(10);

      auto_req();
      rx = 1'b0;
      q.push_back('{cur, 1, cyc + 32769});
      repeat (40000) tick();
      chk("ready_after_overflow", int'(cfg_ready), 1);
      rx = 1'b1;
      wait_q(10);
      repeat (5) tick();

      tx_busy   = 1'b1;
      cfg_valid = 1'b1;
      cfg_dvsr  = 11'd100;
      tick();
      cfg_valid = 1'b0;
      repeat (3) tick();
      chk("ready_drain_reset", int'(cfg_ready), 0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tx_busy = 1'b0;
      cur = 650;
      repeat (6) tick();
      chk("dvsr_after_reset", int'(dvsr), 650);
      chk("ready_after_reset", int'(cfg_ready), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
